// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the 5-stage pipeline datapath (master) and its hazard controller (slave).
// Everything here is a level sampled once per clock; mc_start/mc_done are single-cycle pulses.
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // Handshake rule: no valid/ready pairs. Each *_valid qualifies its stage's fields in
  // the same cycle, and the controller answers combinationally in that cycle.
  // mc_start is a one-cycle request and mc_done a one-cycle completion.
  logic                  ex_valid;
  logic                  ex_is_branch;
  logic                  ex_branch_taken;
  logic                  ex_pred_taken;
  logic                  ex_is_multicycle;
  logic                  ex_rd_we;
  logic                  ex_rd_is_load;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  id_valid;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  mem_busy;
  logic                  mc_done;

  logic                  mc_start;
  logic                  if_stall;
  logic                  id_stall;
  logic                  ex_stall;
  logic                  id_flush;
  logic                  ex_flush;
  logic                  mem_bubble;
  logic                  irreg_pc_sel;
  logic                  mc_error;
  logic [CNT_W-1:0]      perf_mispredict;
  logic [CNT_W-1:0]      perf_stall_cycles;
  // Debug view of the controller FSM: 0 = RUN, 1 = MC_BUSY.
  logic                  dbgState;

  modport master (
    output ex_valid, ex_is_branch, ex_branch_taken, ex_pred_taken, ex_is_multicycle,
           ex_rd_we, ex_rd_is_load, ex_rd_addr,
           id_valid, id_rs1_used, id_rs2_used, id_rs1_addr, id_rs2_addr,
           mem_busy, mc_done,
    input  mc_start, if_stall, id_stall, ex_stall, id_flush, ex_flush, mem_bubble,
           irreg_pc_sel, mc_error, perf_mispredict, perf_stall_cycles, dbgState
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_branch_taken, ex_pred_taken, ex_is_multicycle,
           ex_rd_we, ex_rd_is_load, ex_rd_addr,
           id_valid, id_rs1_used, id_rs2_used, id_rs1_addr, id_rs2_addr,
           mem_busy, mc_done,
    output mc_start, if_stall, id_stall, ex_stall, id_flush, ex_flush, mem_bubble,
           irreg_pc_sel, mc_error, perf_mispredict, perf_stall_cycles, dbgState
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline, with a mul/div hold FSM and watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_hazard_controller_if.slave hz
);

  localparam int WD_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic [WD_W-1:0] watchdog;
  logic [WD_W-1:0] watchdogNext;
  logic            mcError;
  logic            mcErrorNext;

  logic mispredict;
  logic loadUse;
  logic rs1Hit;
  logic rs2Hit;
  logic mcFinish;

  logic mcStart;
  logic ifStall;
  logic idStall;
  logic exStall;
  logic idFlush;
  logic exFlush;
  logic memBubble;
  logic irregPcSel;

  assign mispredict = hz.ex_valid && hz.ex_is_branch &&
                      (hz.ex_branch_taken != hz.ex_pred_taken);

  // x0 is hard-wired, so a load targeting it can never create a dependency.
  assign rs1Hit  = hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr);
  assign rs2Hit  = hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr);
  assign loadUse = hz.ex_valid && hz.ex_rd_is_load && hz.ex_rd_we &&
                   (hz.ex_rd_addr != {REG_ADDR_W{1'b0}}) &&
                   hz.id_valid && (rs1Hit || rs2Hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      watchdog <= '0;
      mcError  <= 1'b0;
    end else begin
      state    <= stateNext;
      watchdog <= watchdogNext;
      mcError  <= mcErrorNext;
    end
  end

  always_comb begin
    stateNext    = state;
    watchdogNext = watchdog;
    mcErrorNext  = mcError;
    mcFinish     = 1'b0;
    mcStart      = 1'b0;
    ifStall      = 1'b0;
    idStall      = 1'b0;
    exStall      = 1'b0;
    idFlush      = 1'b0;
    exFlush      = 1'b0;
    memBubble    = 1'b0;
    irregPcSel   = 1'b0;

    // Controls are forced quiet for the whole time reset is held.
    if (rst) begin
      case (state)
        RUN: begin
          if (hz.mem_busy) begin
            // A mispredict waiting behind mem_busy is redirected once memory frees up.
            ifStall = 1'b1;
            idStall = 1'b1;
            exStall = 1'b1;
          end else if (mispredict) begin
            irregPcSel = 1'b1;
            idFlush    = 1'b1;
            exFlush    = 1'b1;
          end else if (hz.ex_valid && hz.ex_is_multicycle) begin
            mcStart      = 1'b1;
            ifStall      = 1'b1;
            idStall      = 1'b1;
            exStall      = 1'b1;
            memBubble    = 1'b1;
            stateNext    = MC_BUSY;
            watchdogNext = '0;
          end else if (loadUse) begin
            ifStall = 1'b1;
            idStall = 1'b1;
            exFlush = 1'b1;
          end
        end

        MC_BUSY: begin
          mcFinish = hz.mc_done || (watchdog == WD_LAST);
          if (mcFinish) begin
            // EX result moves on this cycle; MEM only gets a bubble if it is still held.
            memBubble    = hz.mem_busy;
            stateNext    = RUN;
            watchdogNext = '0;
            if (!hz.mc_done) begin
              mcErrorNext = 1'b1;
            end
          end else begin
            ifStall      = 1'b1;
            idStall      = 1'b1;
            exStall      = 1'b1;
            memBubble    = 1'b1;
            watchdogNext = watchdog + WD_W'(1);
          end
        end

        default: begin
          stateNext = RUN;
        end
      endcase
    end
  end

  assign hz.mc_start     = mcStart;
  assign hz.if_stall     = ifStall;
  assign hz.id_stall     = idStall;
  assign hz.ex_stall     = exStall;
  assign hz.id_flush     = idFlush;
  assign hz.ex_flush     = exFlush;
  assign hz.mem_bubble   = memBubble;
  assign hz.irreg_pc_sel = irregPcSel;
  assign hz.mc_error     = mcError;
  assign hz.dbgState     = (state == MC_BUSY);

`ifdef HAZARD_PERF_CNT_EN
  logic             mispredictActed;
  logic [CNT_W-1:0] perfMispredictQ;
  logic [CNT_W-1:0] perfStallQ;

  assign mispredictActed = (state == RUN) && !hz.mem_busy && mispredict;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfMispredictQ <= '0;
      perfStallQ      <= '0;
    end else begin
      if (mispredictActed && (perfMispredictQ != {CNT_W{1'b1}})) begin
        perfMispredictQ <= perfMispredictQ + CNT_W'(1);
      end
      if (ifStall && (perfStallQ != {CNT_W{1'b1}})) begin
        perfStallQ <= perfStallQ + CNT_W'(1);
      end
    end
  end

  assign hz.perf_mispredict   = perfMispredictQ;
  assign hz.perf_stall_cycles = perfStallQ;
`else
  assign hz.perf_mispredict   = {CNT_W{1'b0}};
  assign hz.perf_stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage in-order pipeline (IF/ID/EX/MEM/WB). Consumes the Execute stage's branch outcome and destination-register control, the Decode stage's source operands, and memory/multi-cycle-unit status. Produces per-stage stall and bubble-insert controls plus the irregular-PC select. Owns a small FSM that holds the pipeline while the multi-cycle execute unit (mul/div) runs, with a watchdog.

Parameters:
REG_ADDR_W, 5, width of architectural register index
MC_TIMEOUT, 64, max cycles to wait for mc_done before flagging mc_error
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
ex_valid  input  1  EX stage holds a valid instruction
ex_is_branch  input  1  EX instruction is branch/jump
ex_branch_taken  input  1  resolved branch outcome
ex_pred_taken  input  1  outcome predicted at fetch
ex_is_multicycle  input  1  EX instruction uses the multi-cycle unit
ex_rd_we  input  1  EX instruction writes rd
ex_rd_is_load  input  1  EX instruction is a load
ex_rd_addr  input  REG_ADDR_W  EX destination register
id_valid  input  1  ID stage holds a valid instruction
id_rs1_used / id_rs2_used  input  1 each  source operand read
id_rs1_addr / id_rs2_addr  input  REG_ADDR_W each  source registers
mem_busy  input  1  data memory not ready; MEM stage must hold
mc_done  input  1  multi-cycle unit result valid (1-cycle pulse)
mc_start  output  1  start pulse to multi-cycle unit
if_stall / id_stall / ex_stall  output  1 each  hold the stage's pipeline register
id_flush / ex_flush / mem_bubble  output  1 each  load a bubble into ID / EX / MEM pipeline register
irreg_pc_sel  output  1  fetch takes irregular PC this cycle
mc_error  output  1  sticky watchdog error
perf_mispredict / perf_stall_cycles  output  CNT_W each  counters (optional feature)

Behaviour:
- Clock/reset: one clock clk; rst asynchronous, active-low. Reset: state=RUN, watchdog=0, mc_error=0, counters=0; all outputs 0 while rst low.
- mispredict = ex_valid & ex_is_branch & (ex_branch_taken != ex_pred_taken).
- load_use = ex_valid & ex_rd_is_load & ex_rd_we & ex_rd_addr!=0 & id_valid & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- Outputs combinational from state and inputs; state/counters registered.
- FSM states: RUN, MC_BUSY.
- RUN, priority high→low:
  1. mem_busy: if/id/ex_stall=1; no flush, no redirect, no mc_start; a pending mispredict is handled the cycle mem_busy drops.
  2. mispredict: irreg_pc_sel=1, id_flush=1, ex_flush=1; no stalls. load_use ignored.
  3. ex_valid & ex_is_multicycle: mc_start=1 (one cycle), if/id/ex_stall=1, mem_bubble=1; next state MC_BUSY, watchdog=0.
  4. load_use: if_stall=id_stall=1, ex_flush=1 for exactly one cycle.
  5. else: all outputs 0.
- MC_BUSY: if/id/ex_stall=1, mem_bubble=1, mc_start=0. Watchdog increments each cycle.
  - mc_done=1: stalls released that same cycle (EX result advances), next RUN.
  - mem_busy in MC_BUSY: no additional effect (already stalled).
  - Watchdog reaches MC_TIMEOUT-1 without mc_done: mc_error←1 (sticky until reset), next RUN, stalls released.
  - mc_done while mem_busy=1: still return to RUN; mem_bubble continues to be driven in that cycle, and stalls follow RUN rule 1 next cycle.
- mc_done in RUN is ignored.
- Reset mid-MC_BUSY: immediate return to RUN; no mc_start emitted after reset deasserts unless a multi-cycle instruction is in EX.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, perf_mispredict increments (saturating at all-ones) on each cycle mispredict is acted on (RUN rule 2). perf_stall_cycles increments on each cycle with if_stall=1. When undefined, both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Mispredict: ex_valid=1, ex_is_branch=1, taken=1, pred=0 → same cycle irreg_pc_sel=id_flush=ex_flush=1, stalls 0; perf_mispredict 0→1.
- Load-use: EX load rd=5, ID rs2=5 used → one cycle if_stall=id_stall=ex_flush=1, then 0. Repeat with rd=0 → no stall.
- Mispredict + load_use together → only flush/redirect, no stall.
- Multi-cycle: ex_is_multicycle=1 → mc_start pulse for 1 cycle; stalls+mem_bubble held 3 cycles; mc_done on 4th cycle → stalls drop that cycle, state RUN.
- Watchdog: MC_TIMEOUT=8, never assert mc_done → mc_error=1 after 8 cycles in MC_BUSY, stalls released, mc_error stays 1 until rst low.
- mem_busy=1 for 2 cycles with mispredict present → 2 cycles all stalls, no redirect; 3rd cycle redirect + flushes; async rst low mid-MC_BUSY → all outputs 0 immediately.
